// File: rtl/lc3b_pkg.sv
// Shared datapath types: the 2-bit destination select, its named values and the bus width.
// Also holds the per-slot mailbox state encoding.
package lc3b_pkg;

  localparam int BUS_W = 16;

  typedef logic [1:0] dest_sel_t;

  localparam dest_sel_t DEST_0 = 2'd0;
  localparam dest_sel_t DEST_1 = 2'd1;
  localparam dest_sel_t DEST_2 = 2'd2;
  localparam dest_sel_t DEST_3 = 2'd3;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/demux4_mailbox_if.sv
// Bus-side valid/ready handshake plus the four destination mailboxes toward their consumers.
// The slave modport is the demux; the master modport is the producer/consumer side.
interface demux4_mailbox_if
  import lc3b_pkg::*;
#(
  parameter int WIDTH = BUS_W
);
  logic [WIDTH-1:0] in_data;
  dest_sel_t        in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out0;
  logic [WIDTH-1:0] out1;
  logic [WIDTH-1:0] out2;
  logic [WIDTH-1:0] out3;
  logic [3:0]       out_valid;
  logic [3:0]       out_ack;

  modport slave (
    input  in_data, in_sel, in_valid, out_ack,
    output in_ready, out0, out1, out2, out3, out_valid
  );

  modport master (
    output in_data, in_sel, in_valid, out_ack,
    input  in_ready, out0, out1, out2, out3, out_valid
  );
endinterface

// File: rtl/mailbox_slot.sv
// One-deep mailbox: a data register and a valid flag. The producer side guarantees wr_en
// only arrives while the slot is empty or being acked in the same cycle.
//
//   state      | meaning
//   -----------+-----------------------------------------------
//   SLOT_EMPTY | no undelivered data; ack is ignored
//   SLOT_FULL  | data_o holds undelivered data; valid_o = 1
module mailbox_slot
  import lc3b_pkg::*;
#(
  parameter int WIDTH = BUS_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             ack,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o
);

  slot_state_t      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  // A write in the same cycle as an ack keeps the slot full with the new data.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    case (state_q)
      SLOT_EMPTY: begin
        if (wr_en) begin
          state_d = SLOT_FULL;
          data_d  = wr_data;
        end
      end
      SLOT_FULL: begin
        if (wr_en) begin
          data_d = wr_data;
        end else if (ack) begin
          state_d = SLOT_EMPTY;
        end
      end
      default: state_d = SLOT_EMPTY;
    endcase
  end

  assign data_o  = data_q;
  assign valid_o = (state_q == SLOT_FULL);

endmodule

// File: rtl/demux4_mailbox.sv
// Routes one bus value into one of four mailbox slots selected by in_sel; stalls the producer
// while the target slot is full and not being acked. DEMUX_STALL_CNT_EN adds a saturating stall counter.
module demux4_mailbox
  import lc3b_pkg::*;
#(
  parameter int WIDTH   = BUS_W,
  parameter int STALL_W = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  demux4_mailbox_if.slave     bus
`ifdef DEMUX_STALL_CNT_EN
  ,
  output logic [STALL_W-1:0]  stall_count
`endif
);

  logic [WIDTH-1:0] slot_data [4];
  logic [3:0]       slot_valid;
  logic [3:0]       wr_en;
  logic             in_ready;
  logic             accept;

  // An ack to the selected slot frees it for a write in the same cycle.
  assign in_ready = ~slot_valid[bus.in_sel] | bus.out_ack[bus.in_sel];
  assign accept   = bus.in_valid & in_ready;

  always_comb begin
    wr_en = '0;
    if (accept) begin
      wr_en[bus.in_sel] = 1'b1;
    end
  end

  for (genvar n = 0; n < 4; n++) begin : g_slot
    mailbox_slot #(.WIDTH(WIDTH)) u_slot (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (wr_en[n]),
      .wr_data (bus.in_data),
      .ack     (bus.out_ack[n]),
      .data_o  (slot_data[n]),
      .valid_o (slot_valid[n])
    );
  end

  assign bus.in_ready  = in_ready;
  assign bus.out0      = slot_data[DEST_0];
  assign bus.out1      = slot_data[DEST_1];
  assign bus.out2      = slot_data[DEST_2];
  assign bus.out3      = slot_data[DEST_3];
  assign bus.out_valid = slot_valid;

`ifdef DEMUX_STALL_CNT_EN
  logic [STALL_W-1:0] stall_q, stall_d;

  // Saturates at all-ones; only reset clears it.
  always_comb begin
    stall_d = stall_q;
    if (bus.in_valid && !in_ready && !(&stall_q)) begin
      stall_d = stall_q + {{(STALL_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_count = stall_q;
`endif

endmodule
